// File: rtl/gem_cluster_match_seq.sv
// Buffers converted GEM clusters for one event window and, on request, scans them
// sequentially for the best ALCT/CLCT-window match (smallest |dxky|, lowest index on ties).
module gem_cluster_match_seq #(
    parameter int MXCLST   = 8,
    parameter int MXCLSTB  = 3,
    parameter int MXXKYB   = 10,
    parameter int WIREBITS = 7
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clst_vpf,
    input  logic [13:0]         clst_data,
    input  logic                clst_me1a,
    input  logic [WIREBITS-1:0] clst_wire_lo,
    input  logic [WIREBITS-1:0] clst_wire_hi,
    input  logic [MXXKYB-1:0]   clst_xky_lo,
    input  logic [MXXKYB-1:0]   clst_xky_hi,
    input  logic [MXXKYB-1:0]   clst_xky_mi,
    input  logic                flush,
    input  logic                req,
    input  logic [WIREBITS-1:0] req_alct_wg,
    input  logic [MXXKYB-1:0]   req_clct_xky,
    input  logic                req_clct_me1a,
    output logic                busy,
    output logic                done,
    output logic                match_found,
    output logic [MXCLSTB-1:0]  match_idx,
    output logic [13:0]         match_cluster,
    output logic [MXXKYB-1:0]   match_dxky,
    output logic [MXCLSTB:0]    clst_count,
    output logic                overflow
);

    typedef struct packed {
        logic [13:0]         data;
        logic                me1a;
        logic [WIREBITS-1:0] wlo;
        logic [WIREBITS-1:0] whi;
        logic [MXXKYB-1:0]   klo;
        logic [MXXKYB-1:0]   khi;
        logic [MXXKYB-1:0]   kmi;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [MXCLSTB:0] DEPTH = (MXCLSTB+1)'(MXCLST);
    localparam logic [MXCLSTB:0] ONE   = (MXCLSTB+1)'(1);

    entry_t                r_buf [MXCLST];
    state_t                r_state;
    logic [MXCLSTB:0]      r_count;
    logic [MXCLSTB:0]      r_n;
    logic [MXCLSTB-1:0]    r_idx;
    logic                  r_ovf;
    logic [WIREBITS-1:0]   r_wg;
    logic [MXXKYB-1:0]     r_xky;
    logic                  r_me1a;
    logic                  r_bfound;
    logic [MXCLSTB-1:0]    r_bidx;
    logic [13:0]           r_bclst;
    logic [MXXKYB-1:0]     r_bdxky;
    logic                  r_done;
    logic                  r_found;
    logic [MXCLSTB-1:0]    r_midx;
    logic [13:0]           r_mclst;
    logic [MXXKYB-1:0]     r_mdxky;

    entry_t                w_ent;
    logic                  w_match;
    logic [MXXKYB:0]       w_diff;
    logic [MXXKYB:0]       w_mag;
    logic [MXXKYB-1:0]     w_dxky;
    logic                  w_take;
    logic                  w_last;
    logic                  w_wr;

    assign w_wr    = clst_vpf && !flush && (r_count < DEPTH);
    assign w_ent   = r_buf[r_idx];
    assign w_match = (w_ent.me1a == r_me1a) &&
                     (w_ent.wlo <= r_wg)  && (r_wg  <= w_ent.whi) &&
                     (w_ent.klo <= r_xky) && (r_xky <= w_ent.khi);
    // Difference taken one bit wider so the sign survives; magnitude keeps MXXKYB bits.
    assign w_diff  = {1'b0, r_xky} - {1'b0, w_ent.kmi};
    assign w_mag   = w_diff[MXXKYB] ? -w_diff : w_diff;
    assign w_dxky  = w_mag[MXXKYB-1:0];
    assign w_take  = w_match && (!r_bfound || (w_dxky < r_bdxky));
    assign w_last  = ({1'b0, r_idx} == (r_n - ONE));

    always_ff @(posedge clock) begin
        if (w_wr)
            r_buf[r_count[MXCLSTB-1:0]] <= '{clst_data, clst_me1a, clst_wire_lo, clst_wire_hi,
                                             clst_xky_lo, clst_xky_hi, clst_xky_mi};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clst_vpf) begin
            if (r_count < DEPTH) r_count <= r_count + ONE;
            else                 r_ovf   <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_idx    <= '0;
            r_wg     <= '0;
            r_xky    <= '0;
            r_me1a   <= 1'b0;
            r_bfound <= 1'b0;
            r_bidx   <= '0;
            r_bclst  <= '0;
            r_bdxky  <= '0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_midx   <= '0;
            r_mclst  <= '0;
            r_mdxky  <= '0;
        end else if (flush) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_bfound <= 1'b0;
            r_bidx   <= '0;
            r_bclst  <= '0;
            r_bdxky  <= '0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_midx   <= '0;
            r_mclst  <= '0;
            r_mdxky  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (req) begin
                        r_wg     <= req_alct_wg;
                        r_xky    <= req_clct_xky;
                        r_me1a   <= req_clct_me1a;
                        r_n      <= r_count;
                        r_idx    <= '0;
                        r_bfound <= 1'b0;
                        r_bidx   <= '0;
                        r_bclst  <= '0;
                        r_bdxky  <= '0;
                        if (r_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_found <= 1'b0;
                            r_midx  <= '0;
                            r_mclst <= '0;
                            r_mdxky <= '0;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_take) begin
                        r_bfound <= 1'b1;
                        r_bidx   <= r_idx;
                        r_bclst  <= w_ent.data;
                        r_bdxky  <= w_dxky;
                    end
                    r_idx <= r_idx + 1'b1;
                    // Publish straight from the last compare so results line up with done.
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_found <= w_take | r_bfound;
                        r_midx  <= w_take ? r_idx      : r_bidx;
                        r_mclst <= w_take ? w_ent.data : r_bclst;
                        r_mdxky <= w_take ? w_dxky     : r_bdxky;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign match_found   = r_found;
    assign match_idx     = r_midx;
    assign match_cluster = r_mclst;
    assign match_dxky    = r_mdxky;
    assign clst_count    = r_count;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_gem_cluster_match_seq.sv
// Directed bench for gem_cluster_match_seq: hand-computed match results, latency and buffer control.
module tb_gem_cluster_match_seq;

    logic        clock, reset_n;
    logic        clst_vpf, clst_me1a, flush, req, req_clct_me1a;
    logic [13:0] clst_data;
    logic [6:0]  clst_wire_lo, clst_wire_hi, req_alct_wg;
    logic [9:0]  clst_xky_lo, clst_xky_hi, clst_xky_mi, req_clct_xky;
    logic        busy, done, match_found, overflow;
    logic [2:0]  match_idx;
    logic [13:0] match_cluster;
    logic [9:0]  match_dxky;
    logic [3:0]  clst_count;

    int n_vec = 0;
    int n_err = 0;
    int lat, nb, nd;

    gem_cluster_match_seq dut (
        .clock(clock), .reset_n(reset_n), .clst_vpf(clst_vpf), .clst_data(clst_data),
        .clst_me1a(clst_me1a), .clst_wire_lo(clst_wire_lo), .clst_wire_hi(clst_wire_hi),
        .clst_xky_lo(clst_xky_lo), .clst_xky_hi(clst_xky_hi), .clst_xky_mi(clst_xky_mi),
        .flush(flush), .req(req), .req_alct_wg(req_alct_wg), .req_clct_xky(req_clct_xky),
        .req_clct_me1a(req_clct_me1a), .busy(busy), .done(done), .match_found(match_found),
        .match_idx(match_idx), .match_cluster(match_cluster), .match_dxky(match_dxky),
        .clst_count(clst_count), .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [13:0] d, input logic m, input logic [6:0] wl, input logic [6:0] wh,
                      input logic [9:0] kl, input logic [9:0] kh, input logic [9:0] km);
        clst_vpf = 1'b1; clst_data = d; clst_me1a = m;
        clst_wire_lo = wl; clst_wire_hi = wh;
        clst_xky_lo = kl; clst_xky_hi = kh; clst_xky_mi = km;
        @(negedge clock);
        clst_vpf = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
    endtask

    // Returns cycles from request edge to done (-1 on timeout) and busy cycles seen.
    task automatic do_req(input logic [6:0] wg, input logic [9:0] xk, input logic m,
                          output int l, output int b);
        req = 1'b1; req_alct_wg = wg; req_clct_xky = xk; req_clct_me1a = m;
        l = -1; b = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            req = 1'b0;
            if (busy) b++;
            if (done) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic chk_res(input string tag, input logic f, input logic [2:0] ix,
                           input logic [13:0] cl, input logic [9:0] dx);
        chk({tag, ".found"}, match_found, f);
        chk({tag, ".idx"}, match_idx, ix);
        chk({tag, ".cluster"}, match_cluster, cl);
        chk({tag, ".dxky"}, match_dxky, dx);
    endtask

    initial begin
        reset_n = 1'b0; clst_vpf = 0; clst_data = 0; clst_me1a = 0;
        clst_wire_lo = 0; clst_wire_hi = 0; clst_xky_lo = 0; clst_xky_hi = 0; clst_xky_mi = 0;
        flush = 0; req = 0; req_alct_wg = 0; req_clct_xky = 0; req_clct_me1a = 0;
        repeat (2) @(negedge clock);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.count", clst_count, 0);
        chk("rst.ovf", overflow, 0);
        chk_res("rst", 0, 0, 0, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic: e0 and e1 both dxky=5, lower index wins.
        wr(14'h0AA, 0, 10, 20, 100, 140, 120);
        wr(14'h0BB, 0, 10, 20, 110, 150, 130);
        wr(14'h0CC, 0, 10, 20, 300, 340, 320);
        chk("t1.count", clst_count, 3);
        do_req(15, 125, 0, lat, nb);
        chk("t1.lat", lat, 4);
        chk("t1.busy", nb, 4);
        chk_res("t1", 1, 0, 14'h0AA, 5);
        @(negedge clock);
        chk("t1.done_pulse", done, 0);
        chk("t1.hold", match_cluster, 14'h0AA);

        // me1a-only mismatch at dxky=0 skipped; tie at dxky=4 keeps idx 1.
        do_flush();
        wr(14'h111, 1, 10, 20, 100, 140, 125);
        wr(14'h222, 0, 10, 20, 100, 140, 121);
        wr(14'h333, 0, 10, 20, 100, 140, 129);
        do_req(15, 125, 0, lat, nb);
        chk("t2.lat", lat, 4);
        chk_res("t2", 1, 1, 14'h222, 4);

        // Second req while scanning is ignored: only one done pulse.
        @(negedge clock);
        nd = 0;
        req_alct_wg = 15; req_clct_xky = 125; req_clct_me1a = 0;
        for (int i = 0; i < 10; i++) begin
            req = (i == 0 || i == 2);
            @(negedge clock);
            if (done) nd++;
        end
        req = 1'b0;
        chk("t3.ndone", nd, 1);
        chk("t3.idx", match_idx, 1);

        // Flush clears results; empty request finishes immediately.
        do_flush();
        chk_res("t4.flush", 0, 0, 0, 0);
        do_req(15, 125, 0, lat, nb);
        chk("t4.lat", lat, 1);
        chk("t4.busy", nb, 1);
        chk("t4.found", match_found, 0);
        @(negedge clock);
        chk("t4.busy_off", busy, 0);

        // Overflow, flush, same-cycle flush+write.
        for (int i = 0; i < 9; i++) wr(14'(i), 0, 0, 1, 0, 1, 0);
        chk("t5.count", clst_count, 8);
        chk("t5.ovf", overflow, 1);
        do_flush();
        chk("t5.fcount", clst_count, 0);
        chk("t5.fovf", overflow, 0);
        flush = 1'b1; clst_vpf = 1'b1;
        @(negedge clock);
        flush = 1'b0; clst_vpf = 1'b0;
        chk("t5.fwcount", clst_count, 0);

        // Flush mid-scan aborts without done.
        wr(14'h0AA, 0, 10, 20, 100, 140, 120);
        wr(14'h0BB, 0, 10, 20, 110, 150, 130);
        wr(14'h0CC, 0, 10, 20, 300, 340, 320);
        req = 1'b1; req_alct_wg = 15; req_clct_xky = 125; req_clct_me1a = 0;
        @(negedge clock);
        req = 1'b0;
        chk("t6.busy_on", busy, 1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("t6.busy_off", busy, 0);
        chk("t6.count", clst_count, 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) nd++;
            @(negedge clock);
        end
        chk("t6.ndone", nd, 0);
        chk_res("t6", 0, 0, 0, 0);

        // Inclusive window bounds and one-beyond.
        wr(14'h0AB, 0, 10, 20, 100, 140, 120);
        do_req(20, 100, 0, lat, nb);
        chk("t7.lat", lat, 2);
        chk_res("t7.hi_lo", 1, 0, 14'h0AB, 20);
        @(negedge clock);
        do_req(10, 140, 0, lat, nb);
        chk_res("t7.lo_hi", 1, 0, 14'h0AB, 20);
        @(negedge clock);
        do_req(21, 100, 0, lat, nb);
        chk_res("t7.wg_out", 0, 0, 0, 0);
        @(negedge clock);
        do_req(20, 99, 0, lat, nb);
        chk_res("t7.xky_out", 0, 0, 0, 0);
        @(negedge clock);

        // Asynchronous reset mid-scan.
        wr(14'h0CD, 0, 10, 20, 100, 140, 120);
        req = 1'b1; req_alct_wg = 15; req_clct_xky = 120; req_clct_me1a = 0;
        @(negedge clock);
        req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t8.busy", busy, 0);
        chk("t8.count", clst_count, 0);
        chk("t8.done", done, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gem_cluster_match_seq.md
# gem_cluster_match_seq

Buffers the converted GEM clusters produced each bunch crossing by the cluster-to-CSC wire/halfstrip ROM stage, one cluster per clock. On a match request carrying an ALCT key wiregroup and a CLCT key position in 1/8-strip units, it scans the buffer sequentially and reports the best matching cluster. It sits directly downstream of the converter and feeds the GEM-CSC correlation logic in the TMB.

## Interface
Parameters:
- MXCLST, 8, buffer depth (clusters per event window), power of two
- MXCLSTB, 3, log2(MXCLST)
- MXXKYB, 10, 1/8-strip key bits
- WIREBITS, 7, wiregroup bits

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- clst_vpf  in  1  converted cluster valid, write strobe
- clst_data  in  14  raw cluster word
- clst_me1a  in  1  cluster maps to ME1a
- clst_wire_lo, clst_wire_hi  in  WIREBITS  windowed wiregroup range
- clst_xky_lo, clst_xky_hi, clst_xky_mi  in  MXXKYB  windowed key range and centre
- flush  in  1  clear buffer, abort scan
- req  in  1  match request strobe
- req_alct_wg  in  WIREBITS  ALCT key wiregroup
- req_clct_xky  in  MXXKYB  CLCT key, 1/8 strip
- req_clct_me1a  in  1  CLCT in ME1a
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, result valid
- match_found  out  1  at least one entry matched
- match_idx  out  MXCLSTB  winning buffer index
- match_cluster  out  14  winning raw cluster word
- match_dxky  out  MXXKYB  |req_clct_xky - xky_mi| of winner
- clst_count  out  MXCLSTB+1  entries stored
- overflow  out  1  sticky: write dropped while full

## Operation
- Write: clst_vpf=1 and clst_count<MXCLST stores all clst_* fields at index clst_count; count increments. Full: write dropped, overflow set; overflow clears only on flush/reset.
- Writes are accepted in any state; entries written after a req are not scanned by that req.
- States: IDLE, SCAN, DONE.
- IDLE: req=1 latches req_* fields and snapshot N=clst_count; best registers cleared; index=0; go SCAN. If N=0, go DONE directly.
- SCAN: compare entry[index]; index increments each cycle; after index=N-1 go DONE.
- DONE: done=1 for one cycle, publish result, go IDLE.
- Entry matches iff me1a==req_clct_me1a, wire_lo<=req_alct_wg<=wire_hi, xky_lo<=req_clct_xky<=xky_hi (inclusive, unsigned).
- Among matches, the smallest dxky wins; ties keep the lower index (strict less-than replaces).
- dxky is computed at MXXKYB+1 bits and its magnitude is truncated to MXXKYB bits.
- Results (match_found, match_idx, match_cluster, match_dxky) are held until the next DONE, flush, or reset. No match: match_found=0 and the other result fields are 0.
- req when not IDLE: ignored.
- flush: highest priority; count=0, overflow=0, state=IDLE, results=0, no done. A same-cycle write or req is dropped.
- busy=1 in SCAN and DONE.

## Timing
- Reset: all outputs 0; state IDLE; buffer contents don't-care (count=0).
- Write at edge T: clst_count updated at T+1.
- req sampled at edge T with N>0: SCAN for N cycles (T+1..T+N), done high for cycle T+N+1, results valid from T+N+1.
- N=0: done at T+1, match_found=0.
- Next req is accepted in the cycle after done.
- Asynchronous reset mid-scan: immediate return to reset values, no done.

## Test plan
- Write 3 clusters (me1b; wire 10..20; xky 100..140, mi 120 / 110..150, mi 130 / 300..340), req wg=15, xky=125, me1a=0 -> done at T+4, match_found=1, idx=0, dxky=5.
- Two entries with equal dxky=4 at idx 1 and 2 -> idx=1. An entry with only the me1a flag mismatching -> not selected.
- req with empty buffer -> done at T+1, match_found=0, busy high 1 cycle.
- Write 9 clusters -> clst_count=8, overflow=1. Flush -> count=0, overflow=0. Same-cycle flush+write -> count=0.
- Flush asserted during SCAN -> busy drops next cycle, no done pulse, results 0. req during busy -> ignored, single done.
- Boundary: req_alct_wg equal to wire_hi, and req_clct_xky equal to xky_lo -> match. Value one beyond either bound -> no match.
